// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter for the shared memory/I/O bus: one transaction at a time,
// decoded to RAM, the LED register (write) or the switch port (read). All outputs registered.
module mem_bus_arbiter #(
  parameter int unsigned        ADDR_W   = 9,
  parameter int unsigned        DATA_W   = 16,
  parameter logic [ADDR_W-1:0]  LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0]  SW_ADDR  = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_cmd0,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [1:0]        req_cmd1,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic              ready0,
  output logic              ready1,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  input  logic [7:0]        sw_in,
  output logic              led_en
);

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RDWAIT,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic              rr_last;
  logic              gnt;
  logic [1:0]        lat_cmd;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic              valid0, valid1, any_req, sel1;
  logic [1:0]        sel_cmd;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_is_ram, lat_is_ram;
  logic [DATA_W-1:0] sw_word;

  logic              ready0_d, ready1_d, led_en_d;
  logic [DATA_W-1:0] rdata_d, write_data_d;
  logic [1:0]        mem_cmd_d;
  logic [ADDR_W-1:0] mem_addr_d;

  assign valid0  = (req_cmd0 == MREAD) || (req_cmd0 == MWRITE);
  assign valid1  = (req_cmd1 == MREAD) || (req_cmd1 == MWRITE);
  assign any_req = valid0 || valid1;
  // Port 1 wins when it is alone, or on a tie when port 0 had the previous grant.
  assign sel1    = valid1 && (!valid0 || !rr_last);

  assign sel_cmd    = sel1 ? req_cmd1   : req_cmd0;
  assign sel_addr   = sel1 ? req_addr1  : req_addr0;
  assign sel_wdata  = sel1 ? req_wdata1 : req_wdata0;
  assign sel_is_ram = !sel_addr[ADDR_W-1];
  assign lat_is_ram = !lat_addr[ADDR_W-1];
  assign sw_word    = {{(DATA_W-8){1'b0}}, sw_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (any_req) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = (lat_is_ram && lat_cmd == MREAD) ? S_RDWAIT : S_RESP;
      S_RDWAIT: state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last   <= 1'b1;
      gnt       <= 1'b0;
      lat_cmd   <= MNONE;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (state == S_IDLE && any_req) begin
      rr_last   <= sel1;
      gnt       <= sel1;
      lat_cmd   <= sel_cmd;
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
    end
  end

  // Bus outputs are computed one cycle early from the selected request so that the
  // registered values line up with the ACCESS and RESP states.
  always_comb begin
    mem_cmd_d    = MNONE;
    mem_addr_d   = '0;
    write_data_d = '0;
    led_en_d     = 1'b0;
    ready0_d     = 1'b0;
    ready1_d     = 1'b0;
    rdata_d      = '0;
    if (state == S_IDLE && any_req) begin
      mem_addr_d   = sel_addr;
      write_data_d = sel_wdata;
      mem_cmd_d    = sel_is_ram ? sel_cmd : MNONE;
      led_en_d     = (sel_addr == LED_ADDR) && (sel_cmd == MWRITE);
    end
    if (state_nxt == S_RESP) begin
      ready0_d = !gnt;
      ready1_d = gnt;
      if (state == S_RDWAIT) begin
        rdata_d = read_data;
      end else if (lat_cmd == MREAD && lat_addr == SW_ADDR) begin
        rdata_d = sw_word;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_cmd    <= MNONE;
      mem_addr   <= '0;
      write_data <= '0;
      led_en     <= 1'b0;
      ready0     <= 1'b0;
      ready1     <= 1'b0;
      rdata      <= '0;
    end else begin
      mem_cmd    <= mem_cmd_d;
      mem_addr   <= mem_addr_d;
      write_data <= write_data_d;
      led_en     <= led_en_d;
      ready0     <= ready0_d;
      ready1     <= ready1_d;
      rdata      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed transaction table, multi-cycle corner sequences and a
// randomized phase checked every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_cmd0, req_cmd1;
  logic [8:0]  req_addr0, req_addr1;
  logic [15:0] req_wdata0, req_wdata1;
  logic        ready0, ready1, led_en;
  logic [15:0] rdata, write_data, read_data;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [7:0]  sw_in;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(9), .DATA_W(16), .LED_ADDR(9'h100), .SW_ADDR(9'h140)
  ) dut (
    .clk(clk), .reset(reset),
    .req_cmd0(req_cmd0), .req_addr0(req_addr0), .req_wdata0(req_wdata0),
    .req_cmd1(req_cmd1), .req_addr1(req_addr1), .req_wdata1(req_wdata1),
    .ready0(ready0), .ready1(ready1), .rdata(rdata),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .write_data(write_data),
    .read_data(read_data), .sw_in(sw_in), .led_en(led_en)
  );

  // RAM environment: synchronous write, read data one cycle after the address.
  logic [15:0] ram [0:511];
  logic        ram_init = 1'b0;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 512; i++) ram[i] <= 16'(i * 7 + 3);
    end else if (mem_cmd == MWRITE) begin
      ram[mem_addr] <= write_data;
    end
    read_data <= ram[mem_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_reqs();
    req_cmd0 = MNONE; req_addr0 = '0; req_wdata0 = '0;
    req_cmd1 = MNONE; req_addr1 = '0; req_wdata1 = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_reqs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit          port;
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  sw;
    logic [1:0]  exp_mcmd;
    int          exp_led;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int lat = -1, led_cnt = 0, cmd_cnt = 0, other = 0;
    logic [1:0]  seen_cmd = MNONE;
    logic [8:0]  seen_addr = '0;
    logic [15:0] seen_wd = '0, got_rd = '0;
    bit done = 0;
    @(negedge clk);
    sw_in = v.sw;
    idle_reqs();
    if (v.port) begin req_cmd1 = v.cmd; req_addr1 = v.addr; req_wdata1 = v.wdata; end
    else        begin req_cmd0 = v.cmd; req_addr0 = v.addr; req_wdata0 = v.wdata; end
    for (int n = 1; n <= 8 && !done; n++) begin
      @(posedge clk); #1;
      if (mem_cmd != MNONE) begin
        cmd_cnt++; seen_cmd = mem_cmd; seen_addr = mem_addr; seen_wd = write_data;
      end
      if (led_en) begin led_cnt++; seen_wd = write_data; end
      if (v.port ? ready0 : ready1) other++;
      if (v.port ? ready1 : ready0) begin lat = n; got_rd = rdata; done = 1; end
    end
    @(negedge clk);
    idle_reqs();
    @(posedge clk); #1;
    check($sformatf("v%0d_ready_width", idx), v.port ? ready1 : ready0, 0);
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_rdata", idx), got_rd, v.exp_rdata);
    check($sformatf("v%0d_mem_cmd", idx), seen_cmd, v.exp_mcmd);
    check($sformatf("v%0d_mem_cmd_cycles", idx), cmd_cnt, (v.exp_mcmd != MNONE) ? 1 : 0);
    check($sformatf("v%0d_led_cycles", idx), led_cnt, v.exp_led);
    check($sformatf("v%0d_other_ready", idx), other, 0);
    if (v.exp_mcmd != MNONE)
      check($sformatf("v%0d_mem_addr", idx), seen_addr, v.addr);
    if (v.exp_mcmd == MWRITE || v.exp_led != 0)
      check($sformatf("v%0d_write_data", idx), seen_wd, v.wdata);
  endtask

  // Reference model record: bus outputs expected after one clock edge.
  typedef struct packed {
    logic [1:0]  mcmd;
    logic [8:0]  addr;
    logic [15:0] wd;
    logic        led;
    logic        r0;
    logic        r1;
    logic [15:0] rd;
    logic        use_sw;
  } exp_t;

  function automatic bit is_req(input logic [1:0] c);
    return (c == MREAD) || (c == MWRITE);
  endfunction

  vec_t vecs [10];

  initial begin
    int order [8];
    int k, both;
    bit timeout;
    logic [3:0]  first;
    logic [63:0] act;

    vecs[0] = '{0, MWRITE, 9'h010, 16'h00A5, 8'h00, MWRITE, 0, 16'h0000, 2};
    vecs[1] = '{0, MREAD,  9'h010, 16'h0000, 8'h00, MREAD,  0, 16'h00A5, 3};
    vecs[2] = '{1, MWRITE, 9'h100, 16'h0033, 8'h00, MNONE,  1, 16'h0000, 2};
    vecs[3] = '{0, MREAD,  9'h140, 16'h0000, 8'h5C, MNONE,  0, 16'h005C, 2};
    vecs[4] = '{0, MREAD,  9'h1F0, 16'h0000, 8'h5C, MNONE,  0, 16'h0000, 2};
    vecs[5] = '{1, MREAD,  9'h100, 16'h0000, 8'hFF, MNONE,  0, 16'h0000, 2};
    vecs[6] = '{1, MWRITE, 9'h140, 16'hBEEF, 8'h81, MNONE,  0, 16'h0000, 2};
    vecs[7] = '{1, MREAD,  9'h010, 16'h0000, 8'h00, MREAD,  0, 16'h00A5, 3};
    vecs[8] = '{1, MWRITE, 9'h0FF, 16'h1234, 8'h00, MWRITE, 0, 16'h0000, 2};
    vecs[9] = '{0, MREAD,  9'h0FF, 16'h0000, 8'h00, MREAD,  0, 16'h1234, 3};

    reset = 1'b1;
    sw_in = 8'h00;
    idle_reqs();
    ram_init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ram_init = 1'b0;
    @(posedge clk); #1;
    check("reset_outputs", {mem_cmd, mem_addr, write_data, led_en, ready0, ready1, rdata}, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reserved command code 2'b11 is never granted.
    @(negedge clk);
    req_cmd0 = 2'b11; req_addr0 = 9'h010; req_wdata0 = 16'hFFFF;
    k = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (mem_cmd != MNONE || ready0 || ready1 || led_en || mem_addr != 0) k++;
    end
    check("cmd11_idle_cycles_active", k, 0);
    @(negedge clk);
    idle_reqs();

    // Reset asserted while a RAM read sits in RDWAIT.
    @(negedge clk);
    req_cmd0 = MREAD; req_addr0 = 9'h010;
    @(posedge clk); #1;
    check("rst_seq_access_cmd", mem_cmd, MREAD);
    @(posedge clk); #1;
    check("rst_seq_rdwait_quiet", {mem_cmd, ready0, ready1}, 0);
    #2 reset = 1'b1;
    #1 check("rst_async_outputs", {mem_cmd, mem_addr, write_data, led_en, ready0, ready1, rdata}, 0);
    k = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (ready0 || ready1 || mem_cmd != MNONE || led_en) k++;
    end
    check("rst_no_activity", k, 0);
    @(negedge clk);
    reset = 1'b0;
    req_cmd0 = MWRITE; req_addr0 = 9'h020; req_wdata0 = 16'h1111;
    req_cmd1 = MWRITE; req_addr1 = 9'h021; req_wdata1 = 16'h2222;
    first = 4'hF;
    for (int n = 0; n < 6 && first == 4'hF; n++) begin
      @(posedge clk); #1;
      if (ready0 && ready1) first = 4'h3;
      else if (ready0) first = 4'h0;
      else if (ready1) first = 4'h1;
    end
    check("post_reset_tie_winner", first, 0);
    @(negedge clk);
    idle_reqs();
    repeat (3) @(posedge clk);

    // Both ports continuously request RAM reads: grants must alternate starting with port 0.
    pulse_reset();
    req_cmd0 = MREAD; req_addr0 = 9'h010;
    req_cmd1 = MREAD; req_addr1 = 9'h0FF;
    foreach (order[i]) order[i] = 2;
    k = 0; both = 0; timeout = 1;
    for (int n = 0; n < 60 && k < 8; n++) begin
      @(posedge clk); #1;
      if (ready0 && ready1) both++;
      if (ready0) begin order[k] = 0; check($sformatf("alt_rdata_%0d", k), rdata, 16'h00A5); k++; end
      else if (ready1) begin order[k] = 1; check($sformatf("alt_rdata_%0d", k), rdata, 16'h1234); k++; end
    end
    if (k == 8) timeout = 0;
    check("alt_timeout", timeout, 0);
    check("alt_both_ready", both, 0);
    foreach (order[i]) check($sformatf("alt_grant_%0d", i), order[i], i % 2);
    @(negedge clk);
    idle_reqs();

    // Randomized phase against the transaction-level model.
    begin
      exp_t        q [$];
      exp_t        e, z;
      logic [15:0] shadow [512];
      bit          pending [2];
      logic [1:0]  cmd_v [2];
      logic [8:0]  addr_v [2];
      logic [15:0] wd_v [2];
      int          rr, w, r;
      bit          ram_t;

      @(negedge clk);
      reset = 1'b1;
      ram_init = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ram_init = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 512; i++) shadow[i] = 16'(i * 7 + 3);
      rr = 1;
      z = '0;
      for (int p = 0; p < 2; p++) begin
        pending[p] = 0; cmd_v[p] = MNONE; addr_v[p] = '0; wd_v[p] = '0;
      end

      for (int cyc = 0; cyc < 600; cyc++) begin
        for (int p = 0; p < 2; p++) begin
          if (!pending[p]) begin
            r = $urandom_range(0, 9);
            if (r < 3) cmd_v[p] = (r == 0) ? 2'b11 : MNONE;
            else begin
              cmd_v[p] = $urandom_range(0, 1) ? MREAD : MWRITE;
              pending[p] = 1;
            end
            r = $urandom_range(0, 9);
            if (r < 6)       addr_v[p] = 9'($urandom_range(0, 15));
            else if (r == 6) addr_v[p] = 9'h100;
            else if (r == 7) addr_v[p] = 9'h140;
            else if (r == 8) addr_v[p] = 9'h100 | 9'($urandom_range(0, 255));
            else             addr_v[p] = 9'h0FF;
            wd_v[p] = 16'($urandom);
          end
        end
        sw_in = 8'($urandom);
        req_cmd0 = cmd_v[0]; req_addr0 = addr_v[0]; req_wdata0 = wd_v[0];
        req_cmd1 = cmd_v[1]; req_addr1 = addr_v[1]; req_wdata1 = wd_v[1];

        @(posedge clk); #1;
        if (q.size() > 0) begin
          e = q.pop_front();
          if (e.use_sw) e.rd = {8'h00, sw_in};
        end else if (is_req(cmd_v[0]) || is_req(cmd_v[1])) begin
          if (is_req(cmd_v[0]) && is_req(cmd_v[1])) w = 1 - rr;
          else w = is_req(cmd_v[1]) ? 1 : 0;
          rr = w;
          ram_t = addr_v[w] < 9'h100;
          e = z;
          e.mcmd = ram_t ? cmd_v[w] : MNONE;
          e.addr = addr_v[w];
          e.wd   = wd_v[w];
          e.led  = (addr_v[w] == 9'h100) && (cmd_v[w] == MWRITE);
          if (ram_t && cmd_v[w] == MREAD) q.push_back(z);
          begin
            exp_t resp;
            resp = z;
            resp.r0 = (w == 0);
            resp.r1 = (w == 1);
            resp.rd = (ram_t && cmd_v[w] == MREAD) ? shadow[addr_v[w]] : 16'h0000;
            resp.use_sw = (cmd_v[w] == MREAD) && (addr_v[w] == 9'h140);
            q.push_back(resp);
          end
          q.push_back(z);
          if (ram_t && cmd_v[w] == MWRITE) shadow[addr_v[w]] = wd_v[w];
        end else begin
          e = z;
        end
        act = {mem_cmd, mem_addr, write_data, led_en, ready0, ready1, rdata};
        check($sformatf("rand_cycle_%0d", cyc), act,
              {e.mcmd, e.addr, e.wd, e.led, e.r0, e.r1, e.rd});
        if (e.r0) pending[0] = 0;
        if (e.r1) pending[1] = 0;
        @(negedge clk);
      end
      idle_reqs();
    end

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
